ham_pkt_decoder: RTL
====================

# ham_pkt_decoder

Clocked receive endpoint for the 11-bit Hamming-protected packet link driven by the processing core's packet encoder. It accepts `{codeword[6:0], ip[3:0]}` packets with their 2-bit source-control tag over a valid/ready handshake. It computes the Hamming(7,4) syndrome, corrects any single-bit codeword error, and repacks the result into the 8-bit `{data[3:0], ip[3:0]}` data-bucket format. Results are buffered in a small FIFO toward the bucket side, and corrected and dropped packets are counted for debug.

## Interface
Parameters:
- `DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `SRC_CTRL`, 2'd2: control tag value marking valid core-sourced packets.
- `CNT_W`, 8: width of the saturating statistics counters.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  packet present.
- `in_ready`  out  1  decoder can take the packet.
- `in_pkt`  in  11  [3:0] ip, [10:4] codeword cw[6:0] = {D4,D3,D2,P4,D1,P2,P1}.
- `in_ctrl`  in  2  source-control tag.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer takes head entry.
- `out_data`  out  8  [3:0] ip, [7:4] {D4,D3,D2,D1} after correction.
- `corr_cnt`  out  CNT_W  packets with non-zero syndrome (corrected).
- `drop_cnt`  out  CNT_W  packets discarded for control tag ≠ SRC_CTRL.

## Operation
- Accept: a packet transfers on an edge where `in_valid && in_ready`. It is held in stage register S1 (pkt, ctrl, s1_valid).
- Syndrome (combinational from S1):
  - s0 = cw0^cw2^cw4^cw6
  - s1 = cw1^cw2^cw5^cw6
  - s2 = cw3^cw4^cw5^cw6
  - syn = {s2,s1,s0}
- Correction: if syn≠0, invert cw[syn-1]. Out word = {cw6,cw5,cw4,cw2, ip}. The ip bits are never altered.
- S1 drain: on an edge where s1_valid and the FIFO is not full:
  - If ctrl==SRC_CTRL, write the corrected word into the FIFO. If syn≠0, also increment corr_cnt.
  - Otherwise, write nothing and increment drop_cnt.
  - In both cases S1 empties, unless a new packet is accepted on the same edge.
- `in_ready` = !s1_valid || (fifo_count < DEPTH). It is registered-state only, with no combinational path from `out_ready`.
- FIFO: circular buffer with rd/wr pointers and a count of 0..DEPTH. A pop happens when `out_valid && out_ready`. Push and pop on the same edge are allowed at any count, including full, and the count is unchanged.
- Counters saturate at all-ones and never wrap.
- Double-bit errors are undetectable by design: they are "corrected" to a wrong value and counted in corr_cnt.

## Timing
- Reset (rst_n low, async):
  - s1_valid=0, FIFO empty with pointers 0, so out_valid=0 and in_ready=1.
  - out_data=8'h00 (head register cleared), corr_cnt=0, drop_cnt=0.
- Latency: a packet accepted at edge N is written to the FIFO at edge N+1 (if not full), and out_valid is high in the cycle after N+1. The minimum is 2 edges from accept to out-visible.
- Throughput: one packet per cycle while the consumer keeps `out_ready` high.
- Full FIFO with S1 occupied: in_ready=0. A pop at edge M frees the slot, so S1 drains at edge M+1. This is one bubble, intentional to keep paths registered.
- Simultaneous accept and S1 drain on one edge: S1 is reloaded, with no loss.
- Reset asserted mid-operation: all buffered and in-flight packets are discarded immediately and counters clear. Nothing is emitted after deassertion until new packets arrive.
- `out_data` is stable while out_valid=1 and out_ready=0.

## Structure
- Shared package `ham_pkg`:
  - constants PKT_W=11, IP_W=4, CW_W=7, DB_W=8, SRC_CORE=2'd2.
  - packed typedefs `ham_pkt_t` {cw, ip} and `db_word_t` {data, ip}.
  - function `ham74_syndrome`.
  - function `ham74_correct`, reusable by the core-side encoder checks.
- One sub-module: `ham_sync_fifo`, parameterised by width and DEPTH, with push/pop/full/empty/count.

## Test plan
- Clean packet: in_pkt=11'h525, ctrl=2 → out_data=8'hA5 two edges later, corr_cnt=0.
- Single-bit error: in_pkt=11'h425 (cw4 flipped, syn=5) → out_data=8'hA5, corr_cnt=1. Repeat for each of the 7 codeword bits, and confirm the ip bits pass through untouched.
- Wrong tag: in_pkt=11'h525, ctrl=1 → no out_valid, drop_cnt=1, in_ready stays 1.
- Backpressure: out_ready=0, stream 6 packets → exactly DEPTH+1=5 accepted, then in_ready=0. Release out_ready → all 5 emerge in order, then the sixth is accepted. There is one bubble after the first pop.
- Saturation: 300 erroneous packets → corr_cnt holds 8'hFF.
- Async reset: assert rst_n low mid-stream between clock edges → outputs go to reset values immediately, and no stale data appears after release.

Source files
------------

// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) link definitions: packet/bucket layouts plus syndrome and correction helpers.
package ham_pkg;

    localparam int unsigned PKT_W  = 11;
    localparam int unsigned IP_W   = 4;
    localparam int unsigned CW_W   = 7;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned DB_W   = 8;
    localparam logic [1:0]  SRC_CORE = 2'd2;

    // cw = {D4,D3,D2,P4,D1,P2,P1}
    typedef struct packed {
        logic [CW_W-1:0] cw;
        logic [IP_W-1:0] ip;
    } ham_pkt_t;

    // data = {D4,D3,D2,D1}
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IP_W-1:0]   ip;
    } db_word_t;

    function automatic logic [2:0] ham74_syndrome(input logic [CW_W-1:0] cw);
        logic s0, s1, s2;
        s0 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        s1 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        s2 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        return {s2, s1, s0};
    endfunction

    // Syndrome value k points at codeword bit k-1; zero means no flip.
    function automatic logic [CW_W-1:0] ham74_correct(input logic [CW_W-1:0] cw);
        logic [2:0]      syn;
        logic [CW_W-1:0] fixed;
        syn   = ham74_syndrome(cw);
        fixed = cw;
        for (int i = 0; i < CW_W; i++) begin
            if (syn == 3'(i + 1)) fixed[i] = ~cw[i];
        end
        return fixed;
    endfunction

endpackage

// File: rtl/ham_sync_fifo.sv
// Single-clock circular FIFO; head entry is presented directly from storage.
module ham_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FILL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage is cleared on reset so the head reads zero until the first write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + FILL_W'(1);
                2'b01:   count <= count - FILL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ham_pkt_decoder.sv
// Receive endpoint: single-error-correcting Hamming(7,4) decode, tag filtering, output FIFO and debug counters.
module ham_pkt_decoder
    import ham_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [1:0]  SRC_CTRL = SRC_CORE,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PKT_W-1:0] in_pkt,
    input  logic [1:0]       in_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DB_W-1:0]  out_data,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned FILL_W = $clog2(DEPTH + 1);

    ham_pkt_t          s1_pkt;
    logic [1:0]        s1_ctrl;
    logic              s1_valid;
    logic [2:0]        syn_c;
    logic [CW_W-1:0]   cw_fix_c;
    db_word_t          word_c;
    db_word_t          head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FILL_W-1:0] fifo_count;
    logic              accept;
    logic              drain;
    logic              tag_ok;
    logic              push;
    logic              pop;

    assign syn_c    = ham74_syndrome(s1_pkt.cw);
    assign cw_fix_c = ham74_correct(s1_pkt.cw);
    assign word_c   = '{data: {cw_fix_c[6], cw_fix_c[5], cw_fix_c[4], cw_fix_c[2]}, ip: s1_pkt.ip};

    // Readiness depends only on stored state, so out_ready never reaches in_ready.
    assign in_ready  = !s1_valid || (fifo_count < FILL_W'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign drain     = s1_valid && !fifo_full;
    assign tag_ok    = (s1_ctrl == SRC_CTRL);
    assign push      = drain && tag_ok;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pkt   <= '0;
            s1_ctrl  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_pkt   <= ham_pkt_t'(in_pkt);
            s1_ctrl  <= in_ctrl;
        end else if (drain) begin
            s1_valid <= 1'b0;
        end
    end

    // Saturating debug counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (push && (syn_c != 3'd0) && (corr_cnt != '1)) corr_cnt <= corr_cnt + CNT_W'(1);
            if (drain && !tag_ok && (drop_cnt != '1))        drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    ham_sync_fifo #(
        .WIDTH (DB_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (word_c),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
